// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq: multi-cycle instruction sequencer for the NPC core.
// Owns the architectural PC, runs a single-outstanding fetch handshake,
// holds the fetched instruction through EXEC, then commits the next PC
// (or trap vector) or parks in HALT on ebreak / fault.
module pc_fetch_seq #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_rsp_valid,
  input  logic [31:0]     ifu_rsp_inst,
  input  logic            ifu_rsp_err,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  output logic            inst_valid,
  input  logic            exe_done,
  input  logic [XLEN-1:0] dnpc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  output logic            halted,
  output logic [1:0]      fault,
  output logic [63:0]     instret
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_FETCH    = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  state_t          state;
  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;

  // A taken trap overrides the datapath's next PC; low bits must be clear.
  assign next_pc         = trap_req ? trap_vec : dnpc;
  assign next_misaligned = |next_pc[1:0];

  // The fetch address is the architectural PC, held stable by construction.
  assign ifu_req_addr = pc;

  // Sequencer FSM; handshake and status outputs are registered alongside state.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      inst          <= 32'd0;
      ifu_req_valid <= 1'b0;
      inst_valid    <= 1'b0;
      halted        <= 1'b0;
      fault         <= FAULT_NONE;
      instret       <= 64'd0;
    end else begin
      case (state)
        BOOT: begin
          state         <= REQ;
          ifu_req_valid <= 1'b1;
        end
        REQ: begin
          if (ifu_req_ready) begin
            state         <= WAIT;
            ifu_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              state  <= HALT;
              halted <= 1'b1;
              fault  <= FAULT_FETCH;
            end else begin
              inst       <= ifu_rsp_inst;
              state      <= EXEC;
              inst_valid <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (exe_done) begin
            inst_valid <= 1'b0;
            if (halt_req) begin
              instret <= instret + 64'd1;
              state   <= HALT;
              halted  <= 1'b1;
            end else if (next_misaligned) begin
              state  <= HALT;
              halted <= 1'b1;
              fault  <= FAULT_MISALIGN;
            end else begin
              pc            <= next_pc;
              instret       <= instret + 64'd1;
              state         <= REQ;
              ifu_req_valid <= 1'b1;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state         <= HALT;
          halted        <= 1'b1;
          ifu_req_valid <= 1'b0;
          inst_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb_pc_fetch_seq: randomized bench for pc_fetch_seq. A reactive driver plays
// memory and execute stages and feeds a transaction-level model; a monitor
// pops expected fetches / executions / halts and compares against the DUT.
module tb_pc_fetch_seq;

  localparam int unsigned XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_rsp_inst;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exe_done, trap_req, halt_req;
  logic [63:0] dnpc, trap_vec;
  logic        halted;
  logic [1:0]  fault;
  logic [63:0] instret;

  always #5 clk = ~clk;

  pc_fetch_seq #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
    .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .exe_done(exe_done), .dnpc(dnpc), .trap_req(trap_req), .trap_vec(trap_vec),
    .halt_req(halt_req), .halted(halted), .fault(fault), .instret(instret)
  );

  typedef struct { logic [63:0] addr; int gap; } fetch_t;
  typedef struct { logic [31:0] inst; logic [63:0] pc; logic [63:0] instret; } exec_t;
  typedef struct { logic [1:0] fault; logic [63:0] pc; logic [63:0] instret; } halt_t;

  fetch_t exp_fetch[$];
  exec_t  exp_exec[$];
  halt_t  exp_halt[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state: architectural PC and retired count.
  logic [63:0] m_pc;
  logic [63:0] m_instret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic push_fetch(input logic [63:0] a, input int gap);
    fetch_t f;
    f.addr = a; f.gap = gap;
    exp_fetch.push_back(f);
  endtask

  task automatic push_exec(input logic [31:0] iw);
    exec_t e;
    e.inst = iw; e.pc = m_pc; e.instret = m_instret;
    exp_exec.push_back(e);
  endtask

  task automatic push_halt(input logic [1:0] f);
    halt_t h;
    h.fault = f; h.pc = m_pc; h.instret = m_instret;
    exp_halt.push_back(h);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_err = 1'b0; ifu_rsp_inst = 32'd0;
    exe_done = 1'b0; trap_req = 1'b0; halt_req = 1'b0; dnpc = 64'd0; trap_vec = 64'd0;
  endtask

  // Random activity on inputs the DUT must ignore in the current state.
  task automatic noise(input bit rsp_ok, input bit done_ok);
    ifu_rsp_valid = rsp_ok ? ($urandom_range(0, 2) == 0) : 1'b0;
    ifu_rsp_err   = 1'($urandom_range(0, 1));
    ifu_rsp_inst  = $urandom;
    exe_done      = done_ok ? ($urandom_range(0, 2) == 0) : 1'b0;
    halt_req      = 1'($urandom_range(0, 1));
    trap_req      = 1'($urandom_range(0, 1));
    dnpc          = rnd64();
    trap_vec      = rnd64();
  endtask

  task automatic apply_reset(input bit rsp_noise);
    quiet();
    rst = 1'b1;
    exp_fetch.delete(); exp_exec.delete(); exp_halt.delete();
    m_pc = RESET_PC; m_instret = 64'd0;
    if (rsp_noise) begin
      ifu_rsp_valid = 1'b1; ifu_rsp_inst = $urandom; ifu_rsp_err = 1'($urandom_range(0, 1));
    end
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_req_valid", 64'(ifu_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_instret", instret, 64'd0);
    step(); step();
    rst = 1'b0;
    push_fetch(RESET_PC, 0);
    #1;
    check("boot_no_req", 64'(ifu_req_valid), 64'd0);
    step();
  endtask

  // One instruction: fetch handshake, response, execute. Updates the model
  // and pushes every expected observation before the DUT can show it.
  task automatic do_instr(input bit zw, input int stall, input bit err, input bit hreq,
                          input bit trap, input logic [63:0] nx_dnpc, input logic [63:0] vec,
                          input bit rst_wait, output bit going);
    int          n;
    logic [31:0] iw;
    logic [63:0] nxt;
    going = 1'b0;
    n = 0;
    while (!ifu_req_valid && n < 8) begin
      noise(1, 1); step(); n++;
    end
    check("req_seen", 64'(ifu_req_valid), 64'd1);
    if (!ifu_req_valid) return;
    if (!zw) repeat ((stall >= 0) ? stall : $urandom_range(0, 4)) begin
      noise(1, 1); step();
    end
    noise(1, 1); ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    if (rst_wait) begin
      apply_reset(1);
      return;
    end
    if (!zw) repeat ($urandom_range(0, 3)) begin
      noise(0, 1); step();
    end
    iw = $urandom;
    noise(0, 1);
    ifu_rsp_valid = 1'b1; ifu_rsp_inst = iw; ifu_rsp_err = err;
    if (err) push_halt(2'b01);
    else     push_exec(iw);
    step();
    if (err) begin
      quiet();
      return;
    end
    if (!zw) repeat ($urandom_range(0, 3)) begin
      noise(1, 0); step();
    end
    noise(1, 0);
    exe_done = 1'b1; halt_req = hreq; trap_req = trap; dnpc = nx_dnpc; trap_vec = vec;
    if (hreq) begin
      m_instret = m_instret + 64'd1;
      push_halt(2'b00);
    end else begin
      nxt = trap ? vec : nx_dnpc;
      if (nxt % 4 != 0) begin
        push_halt(2'b10);
      end else begin
        m_pc = nxt;
        m_instret = m_instret + 64'd1;
        push_fetch(nxt, zw ? 3 : 0);
        going = 1'b1;
      end
    end
    step();
    quiet();
  endtask

  task automatic finish_segment();
    repeat (3) begin
      noise(1, 1); ifu_req_ready = 1'($urandom_range(0, 1)); step();
    end
    quiet();
    check("park_halted", 64'(halted), 64'd1);
    check("pending_fetch", 64'(exp_fetch.size()), 64'd0);
    check("pending_exec", 64'(exp_exec.size()), 64'd0);
    check("pending_halt", 64'(exp_halt.size()), 64'd0);
  endtask

  // Monitor: compares DUT outputs against the expectation queues.
  int   cyc = 0;
  int   last_acc = 0;
  logic prev_iv = 1'b0;
  logic prev_h  = 1'b0;
  always @(negedge clk) begin
    fetch_t f;
    exec_t  e;
    halt_t  h;
    cyc++;
    if (rst) begin
      prev_iv = 1'b0;
      prev_h  = 1'b0;
    end else begin
      check("addr_eq_pc", ifu_req_addr, pc);
      if (ifu_req_valid) begin
        check("req_expected", 64'(exp_fetch.size() != 0), 64'd1);
        if (exp_fetch.size() != 0) begin
          f = exp_fetch[0];
          check("req_addr", ifu_req_addr, f.addr);
          if (ifu_req_ready) begin
            if (f.gap != 0) check("req_gap", 64'(cyc - last_acc), 64'(f.gap));
            last_acc = cyc;
            f = exp_fetch.pop_front();
          end
        end
      end
      if (inst_valid && !prev_iv) begin
        check("exec_expected", 64'(exp_exec.size() != 0), 64'd1);
        if (exp_exec.size() != 0) begin
          e = exp_exec.pop_front();
          check("exec_inst", 64'(inst), 64'(e.inst));
          check("exec_pc", pc, e.pc);
          check("exec_instret", instret, e.instret);
        end
      end
      if (halted && !prev_h) begin
        check("halt_expected", 64'(exp_halt.size() != 0), 64'd1);
        if (exp_halt.size() != 0) begin
          h = exp_halt.pop_front();
          check("halt_fault", 64'(fault), 64'(h.fault));
          check("halt_pc", pc, h.pc);
          check("halt_instret", instret, h.instret);
          check("halt_inst_valid", 64'(inst_valid), 64'd0);
        end
      end
      prev_iv = inst_valid;
      prev_h  = halted;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit going;
    int r;
    logic [63:0] d, v;
    bit t, hq, er;
    quiet();
    step();
    apply_reset(0);

    // Zero-wait sequential stream: 3 cycles per instruction, then ebreak.
    for (int i = 0; i < 6; i++) do_instr(1, 0, 0, 0, 0, m_pc + 64'd4, 64'd0, 0, going);
    do_instr(1, 0, 0, 1, 0, m_pc + 64'd4, 64'd0, 0, going);
    finish_segment();

    // Long ready stall, trap redirect, misaligned next PC.
    apply_reset(0);
    do_instr(0, 5, 0, 0, 0, m_pc + 64'd4, 64'd0, 0, going);
    do_instr(0, -1, 0, 0, 1, 64'h8000_0040, 64'h8000_0100, 0, going);
    do_instr(0, -1, 0, 0, 0, m_pc + 64'd4, 64'd0, 0, going);
    do_instr(0, -1, 0, 0, 0, 64'h8000_0042, 64'd0, 0, going);
    finish_segment();

    // Fetch bus error.
    apply_reset(0);
    do_instr(0, -1, 0, 0, 0, m_pc + 64'd4, 64'd0, 0, going);
    do_instr(0, -1, 1, 0, 0, 64'd0, 64'd0, 0, going);
    finish_segment();

    // Reset while waiting for a response; stale response during BOOT.
    apply_reset(0);
    do_instr(0, -1, 0, 0, 0, m_pc + 64'd4, 64'd0, 0, going);
    do_instr(0, 2, 0, 0, 0, 64'd0, 64'd0, 1, going);
    for (int i = 0; i < 3; i++) do_instr(0, -1, 0, 0, 0, m_pc + 64'd4, 64'd0, 0, going);
    do_instr(0, -1, 0, 1, 0, m_pc + 64'd4, 64'd0, 0, going);
    finish_segment();

    // Randomized programs.
    for (int s = 0; s < 8; s++) begin
      apply_reset(0);
      going = 1'b1;
      for (int k = 0; k < 12 && going; k++) begin
        r = $urandom_range(0, 99);
        t = 1'b0; hq = 1'b0; er = 1'b0; v = 64'd0;
        d = (r < 30) ? m_pc + 64'd4 : (rnd64() & ~64'h3);
        if (r >= 55 && r < 70) begin
          t = 1'b1; v = rnd64() & ~64'h3; d = rnd64();
        end else if (r >= 70 && r < 76) begin
          t = 1'b1; v = rnd64() | 64'($urandom_range(1, 3)); d = rnd64() & ~64'h3;
        end else if (r >= 76 && r < 82) begin
          d = rnd64() | 64'($urandom_range(1, 3));
        end else if (r >= 82 && r < 90) begin
          hq = 1'b1; t = 1'($urandom_range(0, 1)); v = rnd64(); d = rnd64();
        end else if (r >= 90 && r < 95) begin
          er = 1'b1;
        end
        do_instr(0, -1, er, hq, t, d, v, 0, going);
      end
      if (going) do_instr(0, -1, 0, 1, 0, m_pc + 64'd4, 64'd0, 0, going);
      finish_segment();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
